// File: rtl/alu_core_pkg.sv
// Shared opcodes, FSM state encoding and status-flag bit positions for alu_core_param.
package alu_core_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned FLAG_W   = 4;

  localparam logic [OPCODE_W-1:0] OP_MVR = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_LDB = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_STB = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_RDS = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_CLF = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_NOT = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'd12;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'd13;
  localparam logic [OPCODE_W-1:0] OP_INC = 4'd14;
  localparam logic [OPCODE_W-1:0] OP_MUL = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_WB_LO   = 2'd2,
    ST_WB_HI   = 2'd3
  } state_t;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/alu_core_param_seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;

  // Last iteration is the busy cycle whose counter has reached zero
  assign done = busy && (cnt == '0);

  // Latch operands on start, then accumulate one shifted multiplicand per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= CW'(WIDTH - 1);
      mcand   <= (2*WIDTH)'(a);
      mplier  <= b;
      product <= '0;
    end else if (busy) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_core_param.sv
// WIDTH-bit register machine: one instruction per handshake, multi-cycle MUL, {V,N,Z,C} status.
module alu_core_param #(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned REG_COUNT = 16,
  localparam int unsigned RW        = $clog2(REG_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rs1,
  input  logic [RW-1:0]    rs2,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [3:0]       status
);

  import alu_core_pkg::*;

  logic [WIDTH-1:0]   regs [REG_COUNT];
  state_t             state;
  logic [3:0]         flags;
  logic [RW-1:0]      mul_rd;
  logic [RW-1:0]      mul_rd_hi;

  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_wr;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign src_a     = regs[rs1];
  assign src_b     = regs[rs2];
  assign accept    = op_valid && op_ready;
  assign mul_start = accept && (opcode == OP_MUL);
  assign mul_rd_hi = mul_rd + RW'(1);
  assign status    = flags;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle ALU result and flag candidates for opcodes 8..14
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = 1'b0;
    unique case (opcode)
      OP_NOT: begin alu_res = ~src_a;         alu_wr = 1'b1; end
      OP_AND: begin alu_res = src_a & src_b;  alu_wr = 1'b1; end
      OP_OR:  begin alu_res = src_a | src_b;  alu_wr = 1'b1; end
      OP_XOR: begin alu_res = src_a ^ src_b;  alu_wr = 1'b1; end
      OP_ADD: begin
        sum     = (WIDTH+1)'(src_a) + (WIDTH+1)'(src_b);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
        alu_wr  = 1'b1;
      end
      OP_SUB: begin
        alu_res = src_a - src_b;
        alu_c   = (src_a < src_b);
        alu_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
        alu_wr  = 1'b1;
      end
      OP_INC: begin
        sum     = (WIDTH+1)'(src_a) + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = !src_a[WIDTH-1] && alu_res[WIDTH-1];
        alu_wr  = 1'b1;
      end
      default: ;
    endcase
  end

  // Control FSM, register file, flags and output latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_ready  <= 1'b1;
      flags     <= '0;
      mul_rd    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (op_valid) begin
            unique case (opcode)
              OP_MVR: regs[rd] <= src_a;
              OP_LDB: regs[rd] <= imm;
              OP_STB: begin
                data_out  <= src_a;
                out_valid <= 1'b1;
              end
              OP_RDS: begin
                data_out  <= WIDTH'(flags);
                out_valid <= 1'b1;
              end
              OP_CLF: flags <= '0;
              OP_MUL: begin
                mul_rd   <= rd;
                op_ready <= 1'b0;
                state    <= ST_MUL_RUN;
              end
              default: begin
                if (alu_wr) begin
                  regs[rd]      <= alu_res;
                  flags[FLAG_C] <= alu_c;
                  flags[FLAG_Z] <= (alu_res == '0);
                  flags[FLAG_N] <= alu_res[WIDTH-1];
                  flags[FLAG_V] <= alu_v;
                end
              end
            endcase
          end
        end
        ST_MUL_RUN: begin
          if (mul_busy && mul_done) begin
            state <= ST_WB_LO;
          end
        end
        ST_WB_LO: begin
          regs[mul_rd]  <= mul_product[WIDTH-1:0];
          flags[FLAG_C] <= |mul_product[2*WIDTH-1:WIDTH];
          flags[FLAG_Z] <= (mul_product == '0);
          flags[FLAG_N] <= mul_product[WIDTH-1];
          flags[FLAG_V] <= 1'b0;
          state         <= ST_WB_HI;
        end
        ST_WB_HI: begin
          regs[mul_rd_hi] <= mul_product[2*WIDTH-1:WIDTH];
          op_ready        <= 1'b1;
          state           <= ST_IDLE;
        end
        default: begin
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
